// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and state types for the PS/2 keyboard decoder.
//   - scan-code constants (extended prefix, break prefix, arrow keys)
//   - frame receiver FSM states and make/break decode FSM states
//   - key_onehot(): maps an extended arrow scan code to a one-hot key vector
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    // Bit positions in the key vectors (held flags, pulses).
    localparam int NUM_KEYS  = 3;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_ROT   = 2;

    typedef enum logic {
        RX_IDLE,
        RX_BITS
    } rx_state_e;

    typedef enum logic [1:0] {
        D_BASE,
        D_EXT,
        D_BRK,
        D_EXT_BRK
    } dec_state_e;

    // One-hot key vector for an extended code; zero for anything unlisted.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        case (code)
            SC_LEFT:  k[KEY_LEFT]  = 1'b1;
            SC_RIGHT: k[KEY_RIGHT] = 1'b1;
            SC_UP:    k[KEY_ROT]   = 1'b1;
            default:  k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
//   Synchronizes the raw PS/2 clock/data, detects falling edges of the PS/2
//   clock and shifts in an 11-bit frame (start, 8 data LSB first, parity,
//   stop). Frames with stop=1 (and, when PS2_PARITY_CHK_EN is defined, odd
//   parity) are accepted; others, and frames stalled for TIMEOUT_CYC cycles,
//   are rejected.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   code              last accepted data byte
//   code_valid        one-cycle strobe when code updates
//   frame_err         one-cycle strobe on a rejected or timed-out frame
// Configuration macro: PS2_PARITY_CHK_EN (enables odd-parity check).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          dat;

    rx_state_e     state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          parity_ok;
    logic          accept;
    logic          reject;

`ifdef PS2_PARITY_CHK_EN
    logic          par_bit;
    assign parity_ok = ^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign dat     = dat_sync[1];
    assign fall    = clk_prev & ~clk_sync[1];
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Lines idle high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    // bit_cnt 0..7 = data, 8 = parity, 9 = stop.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall && !dat) state_nxt = RX_BITS;
            end
            RX_BITS: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        state_nxt = RX_IDLE;
                        if (dat && parity_ok) accept = 1'b1;
                        else                  reject = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = RX_IDLE;
                    reject    = 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state != RX_BITS) bit_cnt <= '0;
            else if (fall)        bit_cnt <= bit_cnt + 4'd1;

            if (state == RX_BITS && fall && bit_cnt < 4'd8)
                shift <= {dat, shift[7:1]};

            // Counts cycles since the last edge while a frame is open.
            if (state != RX_BITS || fall) tmo_cnt <= '0;
            else if (!tmo_hit)            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (reset)                                      par_bit <= 1'b0;
        else if (state == RX_BITS && fall && bit_cnt == 4'd8) par_bit <= dat;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= reject;
            if (accept) code <= shift;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard front end producing arrow-key press pulses.
//   Frames come from ps2_frame_rx; a make/break decoder tracks E0/F0
//   prefixes and emits one pulse per new press of the extended left, right
//   and up arrows. Held flags suppress typematic repeats until the matching
//   break code arrives.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   left/right/rotate one-cycle press pulses (E0 6B / E0 74 / E0 75)
//   scan_code         last accepted frame byte
//   code_valid        one-cycle strobe when scan_code updates
//   frame_err         one-cycle strobe on an aborted or rejected frame
// Configuration macro: PS2_PARITY_CHK_EN (enables odd-parity check).
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       left,
    output logic       right,
    output logic       rotate,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    dec_state_e          dec, dec_nxt;
    logic [NUM_KEYS-1:0] held, held_nxt;
    logic [NUM_KEYS-1:0] pulse, pulse_nxt;
    logic [NUM_KEYS-1:0] key;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code       (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    assign key = key_onehot(scan_code);

    always_ff @(posedge clk) begin
        if (reset) begin
            dec   <= D_BASE;
            held  <= '0;
            pulse <= '0;
        end else begin
            dec   <= dec_nxt;
            held  <= held_nxt;
            pulse <= pulse_nxt;
        end
    end

    // Only code_valid advances the decoder; frame_err leaves it untouched.
    // key is one-hot, so at most one pulse bit is ever set.
    always_comb begin
        dec_nxt   = dec;
        held_nxt  = held;
        pulse_nxt = '0;
        if (code_valid) begin
            case (dec)
                D_BASE: begin
                    if      (scan_code == SC_EXT) dec_nxt = D_EXT;
                    else if (scan_code == SC_BRK) dec_nxt = D_BRK;
                end
                D_EXT: begin
                    if (scan_code == SC_BRK) begin
                        dec_nxt = D_EXT_BRK;
                    end else begin
                        dec_nxt   = D_BASE;
                        pulse_nxt = key & ~held;
                        held_nxt  = held | key;
                    end
                end
                D_BRK: dec_nxt = D_BASE;
                D_EXT_BRK: begin
                    dec_nxt  = D_BASE;
                    held_nxt = held & ~key;
                end
                default: dec_nxt = D_BASE;
            endcase
        end
    end

    assign left   = pulse[KEY_LEFT];
    assign right  = pulse[KEY_RIGHT];
    assign rotate = pulse[KEY_ROT];

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, the maximum clk cycles allowed between PS/2 falling edges inside one frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard (asynchronous).
REQ-005 SHALL have port ps2_dat  input  1  raw PS/2 data from the keyboard (asynchronous).
REQ-006 SHALL have port left  output  1  one-cycle pulse per new left-arrow press.
REQ-007 SHALL have port right  output  1  one-cycle pulse per new right-arrow press.
REQ-008 SHALL have port rotate  output  1  one-cycle pulse per new up-arrow press.
REQ-009 SHALL have port scan_code  output  8  last accepted frame byte.
REQ-010 SHALL have port code_valid  output  1  one-cycle strobe when scan_code updates.
REQ-011 SHALL have port frame_err  output  1  one-cycle strobe on an aborted or rejected frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_dat through a 2-flop synchronizer each, then detect ps2_clk falling edges from the synchronized signal.
REQ-013 SHALL use a frame FSM with states RX_IDLE and RX_BITS, and a 4-bit bit counter.
REQ-014 In RX_IDLE, on a falling edge with ps2_dat=0 (start bit), SHALL enter RX_BITS; a falling edge with ps2_dat=1 SHALL be ignored.
REQ-015 In RX_BITS, SHALL sample 8 data bits LSB first, then the parity bit, then the stop bit, each on successive falling edges.
REQ-016 On the stop-bit edge, if stop=1 and the frame passes the parity check, SHALL load scan_code and pulse code_valid on the next clk cycle; otherwise SHALL pulse frame_err; in both cases SHALL return to RX_IDLE.
REQ-017 In RX_BITS, if TIMEOUT_CYC cycles pass with no falling edge, SHALL pulse frame_err, discard the partial frame and return to RX_IDLE.
REQ-018 SHALL use a decode FSM with states D_BASE, D_EXT (after E0), D_BRK (after F0) and D_EXT_BRK (after E0 F0), advancing only on code_valid.
REQ-019 From D_BASE, E0 SHALL go to D_EXT and F0 SHALL go to D_BRK; any other byte SHALL stay in D_BASE.
REQ-020 From D_EXT, F0 SHALL go to D_EXT_BRK; any other byte SHALL be decoded as an extended make code and then return to D_BASE.
REQ-021 D_BRK and D_EXT_BRK SHALL each decode the next byte as a break code and then return to D_BASE.
REQ-022 Extended make 6B/74/75 SHALL pulse left/right/rotate respectively, one cycle after code_valid, but only if that key's held flag is clear; the held flag SHALL then be set.
REQ-023 Extended break 6B/74/75 SHALL clear the matching held flag without producing a pulse; typematic repeats therefore produce no pulses.
REQ-024 Non-extended codes and unlisted extended codes SHALL not affect any key output or held flag.
REQ-025 At most one of left/right/rotate SHALL be high in any cycle.
REQ-026 frame_err SHALL not change the decode FSM state.

Reset
REQ-027 Reset SHALL force both FSMs to their idle states (RX_IDLE, D_BASE), clear the bit counter, timeout counter and held flags, and set all outputs to 0 (scan_code=8'h00).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first frame after reset is only accepted if it begins with a fresh start bit.

Configuration
REQ-029 With PS2_PARITY_CHK_EN defined, SHALL require odd parity (data bits plus parity bit contain an odd number of 1s); a frame that fails SHALL raise frame_err and produce no code_valid.
REQ-030 Without PS2_PARITY_CHK_EN, the parity bit SHALL be sampled and ignored; only the stop bit and the timeout SHALL be checked.

Structure
REQ-031 Package ps2_pkg SHALL hold the scan-code constants (E0, F0, 6B, 74, 75) and the RX and decode FSM state enums.
REQ-032 The synchronizer and the frame FSM SHALL be a sub-module ps2_frame_rx; the make/break decode SHALL stay in ps2_key_decoder.

Verification
REQ-033 Frames E0,75 -> exactly one rotate pulse; frames E0,F0,75 -> no pulse; no frame_err in either case.
REQ-034 Frames E0,6B sent three times (typematic repeat) -> one left pulse; after E0,F0,6B followed by E0,6B -> a second left pulse.
REQ-035 Frame byte 74 sent with the parity bit inverted -> with PS2_PARITY_CHK_EN: frame_err pulses, no code_valid; without it: code_valid pulses with scan_code=8'h74.
REQ-036 Frame stopped after 5 bits, then TIMEOUT_CYC+1 idle cycles -> frame_err pulses; a following full E0,74 sequence -> one right pulse.
REQ-037 Reset asserted during the data bits of 6B -> all outputs 0; no pulse comes from the remaining edges of that frame.
REQ-038 Non-extended 6B (keypad 4) -> code_valid with scan_code=8'h6B, and no left pulse.
